// File: rtl/mux16_capture_fifo.sv
// Operand-mux select driver with a show-ahead capture FIFO and valid/ready output.
// Optional macro MUX16_CAPTURE_SRC_TAG_EN stores the push-time select per entry and exposes Out_Src.
module mux16_capture_fifo #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          Clk,
  input  logic          Rst_n,
  input  logic [1:0]    Mode,
  output logic          Sel,
  input  logic [15:0]   S_In,
  input  logic          In_Valid,
  output logic          In_Ready,
  output logic [15:0]   Out_Data,
  output logic          Out_Valid,
  input  logic          Out_Ready,
  output logic [AW:0]   Count,
`ifdef MUX16_CAPTURE_SRC_TAG_EN
  output logic          Out_Src,
`endif
  output logic          Ovf,
  input  logic          Ovf_Clr
);

`ifdef MUX16_CAPTURE_SRC_TAG_EN
  localparam int DW = 17;
`else
  localparam int DW = 16;
`endif
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          alt_q, alt_d;
  logic          ovf_q, ovf_d;
  logic          push, pop, full;
  logic [DW-1:0] wdata;
  logic [DW-1:0] head;

  always_comb begin
    case (Mode)
      2'b01:   Sel = 1'b1;
      2'b10:   Sel = alt_q;
      default: Sel = 1'b0;
    endcase
  end

  assign full      = (count_q == FULL_CNT);
  assign In_Ready  = ~full;
  assign Out_Valid = (count_q != '0);
  assign push      = In_Valid & In_Ready;
  assign pop       = Out_Valid & Out_Ready;
  assign Count     = count_q;
  assign Ovf       = ovf_q;
  assign head      = mem_q[rd_ptr_q];
  assign Out_Data  = head[15:0];

`ifdef MUX16_CAPTURE_SRC_TAG_EN
  assign wdata   = {Sel, S_In};
  assign Out_Src = head[16];
`else
  assign wdata   = S_In;
`endif

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    alt_d    = alt_q;
    ovf_d    = ovf_q;

    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;

    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    // Leaving interleave mode re-arms it so the next interleave run starts on A.
    if (Mode != 2'b10)  alt_d = 1'b0;
    else if (push)      alt_d = ~alt_q;

    // A set and a clear in the same cycle keep the flag set.
    if (In_Valid && full) ovf_d = 1'b1;
    else if (Ovf_Clr)     ovf_d = 1'b0;
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      alt_q    <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      alt_q    <= alt_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage is deliberately unreset; Out_Data is only meaningful while Out_Valid is high.
  always_ff @(posedge Clk) begin
    if (push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: doc/mux16_capture_fifo.md
Name: mux16_capture_fifo

Overview:
- Downstream stage of the 16-bit 2:1 operand mux.
- Drives the mux select line and captures the selected 16-bit word S into a small show-ahead FIFO.
- Presents buffered words to the next datapath stage over a valid/ready handshake.
- Supports fixed-source mode and A/B interleave mode, so the consumer receives A,B,A,B,… without any external select logic.

Parameters:
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- AW, 2, pointer width, equal to log2(DEPTH).

Ports:
- Clk  input  1  rising-edge clock.
- Rst_n  input  1  asynchronous active-low reset.
- Mode  input  2  source mode: 00 = always A (Sel=0), 01 = always B (Sel=1), 10 = alternate A/B, 11 = reserved (behaves as 00).
- Sel  output  1  select to the 16-bit mux (0 = A, 1 = B).
- S_In  input  16  mux output S, sampled the same cycle Sel is driven.
- In_Valid  input  1  upstream presents a word on the mux inputs.
- In_Ready  output  1  FIFO can accept a word this cycle.
- Out_Data  output  16  head-of-FIFO word.
- Out_Valid  output  1  Out_Data holds a valid word.
- Out_Ready  input  1  consumer accepts the head word.
- Count  output  AW+1  number of stored words, 0..DEPTH.
- Ovf  output  1  sticky overflow flag.
- Ovf_Clr  input  1  synchronous clear of Ovf.

Behaviour:
- Reset (Rst_n=0, asynchronous), all of the following are forced:
  - wr_ptr, rd_ptr, Count = 0.
  - alternate toggle alt_q = 0.
  - Ovf = 0.
  - Out_Valid = 0, In_Ready = 1.
  - Sel = 0 when Mode is 00/10/11; Sel = 1 when Mode is 01.
  - Storage contents are not reset; Out_Data is don't-care while Out_Valid=0.
- Sel is combinational from Mode and alt_q:
  - Mode 00/11 -> Sel=0.
  - Mode 01 -> Sel=1.
  - Mode 10 -> Sel=alt_q.
- alt_q behaviour:
  - Toggles on every accepted push while Mode=10.
  - Is forced to 0 on any cycle where Mode≠10, so entering Mode 10 always starts with A.
- Push = In_Valid & In_Ready, where In_Ready = (Count != DEPTH).
  - On push, S_In is written at wr_ptr on the rising edge.
  - wr_ptr increments modulo DEPTH; wrap from DEPTH-1 to 0 is natural pointer rollover.
- Pop = Out_Valid & Out_Ready, where Out_Valid = (Count != 0).
  - Out_Data = mem[rd_ptr], show-ahead and combinational from storage.
  - rd_ptr increments modulo DEPTH on pop.
- Latency: a word pushed in cycle N is visible on Out_Data/Out_Valid in cycle N+1. There is no empty-bypass path.
- Simultaneous push and pop:
  - Count unchanged; both pointers advance.
  - When full, In_Ready=0, so no push occurs even if a pop happens the same cycle. In_Ready rises the cycle after the pop.
  - When empty, only the push takes effect.
- Overflow:
  - In_Valid=1 while Count==DEPTH sets Ovf on the next edge. The word is dropped and alt_q does not toggle.
  - Ovf_Clr=1 clears Ovf.
  - If set and clear conditions occur in the same cycle, set wins.
- Mode change mid-stream: takes effect on Sel combinationally in the same cycle. Stored words are unaffected.
- Count rules: updated +1 on push-only, -1 on pop-only, and never exceeds DEPTH or drops below 0.

Optional Feature:
- Macro: MUX16_CAPTURE_SRC_TAG_EN.
- When defined:
  - Each entry stores the Sel value used at push time as a 17th bit.
  - Adds output port Out_Src (1 bit) = source tag of the head entry (0 = A, 1 = B).
  - Out_Src is valid only while Out_Valid=1.
- When undefined:
  - No tag storage and no Out_Src port.
  - Storage is 16 bits per entry.

Test Plan:
- Reset then Mode=00, push 0x1111 with Out_Ready=0 -> Sel=0, Count=1 next cycle, Out_Valid=1, Out_Data=0x1111.
- Mode=10, A=0xAAAA, B=0x5555, push 4 words back-to-back with Out_Ready=0 -> Sel sequence 0,1,0,1; Count=4; In_Ready=0; pops return 0xAAAA, 0x5555, 0xAAAA, 0x5555.
- Fill to DEPTH=4, hold In_Valid=1 for 2 cycles -> Ovf=1 and Count stays 4. Assert Ovf_Clr with In_Valid=0 -> Ovf=0 next cycle. Assert Ovf_Clr with In_Valid=1 while full -> Ovf stays 1.
- Count=2, push and pop in the same cycle for 6 cycles with incrementing data 0x0001..0x0006 -> Count stays 2, pointers wrap, output order is strictly FIFO.
- Mode=10 after one push (alt_q=1), switch to Mode=00 for 1 cycle, then back to 10 -> first Sel after return = 0.
- Count=3, deassert Rst_n asynchronously mid-cycle -> Count=0, Out_Valid=0, In_Ready=1, Ovf=0 immediately without a clock edge. With MUX16_CAPTURE_SRC_TAG_EN, Out_Src matches the push-time Sel for every popped word.
